load_store_unit: RTL

Memory-stage load/store unit of the RISC-V core. It accepts one load or store request at a time from the execute/memory pipeline over a valid/ready handshake. It drives the DataMem port set (rd_addr0, wr_addr0, wr_din0, we0, wr_strb, rd_dout0) and returns load data or store completion over a valid/ready response channel. It sits directly upstream of DataMem, in the memory-controller role.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_access_check.sv | 35 +++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access-size encoding,
// FSM states and the position of the unsigned-load flag inside wr_strb.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsuSize_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsuState_t;

   localparam int UNSIGNED_BIT = 2;

   // Builds the DataMem strobe: size in the low bits, unsigned-load flag on top.
   function automatic logic [2:0] makeStrobe(input logic unsignedLoad, input logic [1:0] size);
      logic [2:0] strobe;
      strobe = {1'b0, size};
      strobe[UNSIGNED_BIT] = unsignedLoad;
      return strobe;
   endfunction

endpackage

// File: rtl/lsu_access_check.sv
// Combinational legality check for an incoming load/store request.
// Size 3 is always illegal. Alignment is only enforced when the
// LSU_MISALIGN_TRAP_EN macro is defined; otherwise misaligned accesses
// are passed to DataMem as-is.
module lsu_access_check
   import lsu_pkg::*;
(
   input  logic [1:0] size_i,
   input  logic [1:0] addrLow_i,
   output logic       legal_o
);

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif

   logic sizeOk;
   logic misaligned;

   // Decide legality from the size code and the low address bits; a halfword
   // needs addr[0]=0 and a word needs addr[1:0]=0.
   always_comb begin
      sizeOk     = (size_i != 2'd3);
      misaligned = 1'b0;
      if (size_i == SZ_HALF) begin
         misaligned = addrLow_i[0];
      end else if (size_i == SZ_WORD) begin
         misaligned = |addrLow_i;
      end
      legal_o = sizeOk && !(TrapEn && misaligned);
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Accepts one request at a time, drives the
// DataMem port set for a single ACCESS cycle and returns the result on a
// valid/ready response channel. Optional feature macro: LSU_MISALIGN_TRAP_EN
// (rejects misaligned halfword/word accesses, handled in lsu_access_check).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] rd_addr0,
   output logic [ADDR_W-1:0] wr_addr0,
   output logic [DATA_W-1:0] wr_din0,
   output logic              we0,
   output logic [2:0]        wr_strb,
   input  logic [DATA_W-1:0] rd_dout0
);

   lsuState_t         state_q, state_d;
   logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
   logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
   logic [DATA_W-1:0] wrDin_q, wrDin_d;
   logic [DATA_W-1:0] rspRdata_q, rspRdata_d;
   logic [2:0]        wrStrb_q, wrStrb_d;
   logic              we_q, we_d;
   logic              rspErr_q, rspErr_d;
   logic              isStore_q, isStore_d;
   logic              reqLegal;

   lsu_access_check uCheck (
      .size_i    (req_size),
      .addrLow_i (req_addr[1:0]),
      .legal_o   (reqLegal)
   );

   // Next-state logic: a legal request loads the memory-port registers so they
   // are live during ACCESS; the ports are cleared again when ACCESS ends.
   always_comb begin
      state_d    = state_q;
      rdAddr_d   = rdAddr_q;
      wrAddr_d   = wrAddr_q;
      wrDin_d    = wrDin_q;
      rspRdata_d = rspRdata_q;
      wrStrb_d   = wrStrb_q;
      we_d       = 1'b0;
      rspErr_d   = rspErr_q;
      isStore_d  = isStore_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (reqLegal) begin
                  state_d   = ACCESS;
                  isStore_d = req_we;
                  rspErr_d  = 1'b0;
                  if (req_we) begin
                     wrAddr_d = req_addr;
                     wrDin_d  = req_wdata;
                     wrStrb_d = makeStrobe(1'b0, req_size);
                     we_d     = 1'b1;
                  end else begin
                     rdAddr_d = req_addr;
                     wrStrb_d = makeStrobe(req_unsigned, req_size);
                  end
               end else begin
                  state_d    = RESP;
                  rspErr_d   = 1'b1;
                  rspRdata_d = '0;
               end
            end
         end
         ACCESS: begin
            state_d    = RESP;
            rspErr_d   = 1'b0;
            rspRdata_d = isStore_q ? '0 : rd_dout0;
            rdAddr_d   = '0;
            wrAddr_d   = '0;
            wrDin_d    = '0;
            wrStrb_d   = '0;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d    = IDLE;
               rspErr_d   = 1'b0;
               rspRdata_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         rdAddr_q   <= '0;
         wrAddr_q   <= '0;
         wrDin_q    <= '0;
         rspRdata_q <= '0;
         wrStrb_q   <= '0;
         we_q       <= 1'b0;
         rspErr_q   <= 1'b0;
         isStore_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdAddr_q   <= rdAddr_d;
         wrAddr_q   <= wrAddr_d;
         wrDin_q    <= wrDin_d;
         rspRdata_q <= rspRdata_d;
         wrStrb_q   <= wrStrb_d;
         we_q       <= we_d;
         rspErr_q   <= rspErr_d;
         isStore_q  <= isStore_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rspRdata_q;
   assign rsp_err   = rspErr_q;
   assign rd_addr0  = rdAddr_q;
   assign wr_addr0  = wrAddr_q;
   assign wr_din0   = wrDin_q;
   assign we0       = we_q;
   assign wr_strb   = wrStrb_q;

endmodule
